mem_requester: RTL and testbench

MEM_REQUESTER -- requirements
Module: mem_requester

---
 rtl/mem_requester.sv | 195 +++++++++++++++++++
 tb/tb_mem_requester.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_requester.sv
// Single-outstanding memory requester: validates a load/store request, drives the
// RAM controller port, and returns one response per request (error, store ack or load data).
module mem_requester #(
  parameter int unsigned TIMEOUT = 15,
  parameter logic [14:0] BASE_HI = 15'h4000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        ram_en,
  output logic [3:0]  ram_we,
  output logic [16:0] ram_addr,
  output logic [31:0] ram_din,
  output logic [1:0]  ram_mem_op,
  output logic [1:0]  ram_mem_size,
  input  logic        ram_ready,
  input  logic        ram_read_valid,
  input  logic [31:0] ram_dout,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
  // the sender holds payload stable while valid=1 and ready=0.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]    op_q, op_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [16:0]   addr_q, addr_d;
  logic [3:0]    we_q, we_d;
  logic [31:0]   din_q, din_d;
  logic [31:0]   data_q, data_d;
  logic          err_q, err_d;

  logic          req_bad;
  logic [3:0]    req_we;
  logic [31:0]   req_din;
  logic [31:0]   shifted;
  logic [31:0]   load_val;
  logic          complete;

  always_comb begin
    req_bad = 1'b0;
    req_we  = 4'b0000;
    req_din = 32'h0;
    if (req_op != OP_LOAD && req_op != OP_STORE) req_bad = 1'b1;
    if (req_size == 2'b11) req_bad = 1'b1;
    if (req_size == 2'b01 && req_addr[0]) req_bad = 1'b1;
    if (req_size == 2'b10 && req_addr[1:0] != 2'b00) req_bad = 1'b1;
    if (req_addr[31:17] != BASE_HI) req_bad = 1'b1;
    if (req_op == OP_STORE) begin
      case (req_size)
        2'b00: begin
          req_we  = 4'b0001 << req_addr[1:0];
          req_din = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          req_we  = 4'b0011 << {req_addr[1], 1'b0};
          req_din = {2{req_wdata[15:0]}};
        end
        2'b10: begin
          req_we  = 4'b1111;
          req_din = req_wdata;
        end
        default: begin
          req_we  = 4'b0000;
          req_din = 32'h0;
        end
      endcase
    end
  end

  always_comb begin
    shifted  = ram_dout >> {addr_q[1:0], 3'b000};
    load_val = shifted;
    case (size_q)
      2'b00:   load_val = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  // cnt_q is zero only in the first WAIT cycle, which masks a stale sticky read_valid.
  assign cnt_inc  = cnt_q + CW'(1);
  assign complete = (cnt_q != '0) && ram_ready && ((op_q == OP_STORE) || ram_read_valid);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    we_d    = we_q;
    din_d   = din_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr[16:0];
          we_d    = req_bad ? 4'b0000 : req_we;
          din_d   = req_bad ? 32'h0 : req_din;
          cnt_d   = '0;
          data_d  = 32'h0;
          err_d   = req_bad;
          state_d = req_bad ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (ram_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (complete) begin
          if (op_q == OP_LOAD) data_d = load_val;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CW'(TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= 2'b00;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= 17'h0;
      we_q    <= 4'b0000;
      din_q   <= 32'h0;
      data_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      din_q   <= din_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign req_ready    = (state_q == S_IDLE) && !rst;
  assign ram_en       = (state_q == S_ISSUE) || ((state_q == S_WAIT) && !ram_ready);
  assign resp_valid   = (state_q == S_RESP);
  assign resp_data    = data_q;
  assign resp_err     = err_q;
  assign ram_we       = we_q;
  assign ram_din      = din_q;
  assign ram_addr     = addr_q;
  assign ram_mem_op   = op_q;
  assign ram_mem_size = size_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_requester.sv
// Directed and randomized checks of mem_requester against a small RAM-controller model
// and an arithmetic reference of the load/store/error rules.
module tb_mem_requester;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [16:0] ram_addr;
  logic [31:0] ram_din;
  logic [1:0]  ram_mem_op;
  logic [1:0]  ram_mem_size;
  logic        ram_ready;
  logic        ram_read_valid;
  logic [31:0] ram_dout;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  // Controller model: ready when idle, busy 2 cycles after accepting, read_valid one cycle after ready returns.
  logic ctl_ready;
  logic force_low;
  logic rv_pend;
  int   busy;

  assign ram_ready = ctl_ready & ~force_low;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_requester dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_mem_op(ram_mem_op), .ram_mem_size(ram_mem_size),
    .ram_ready(ram_ready), .ram_read_valid(ram_read_valid), .ram_dout(ram_dout),
    .dbg_state(dbg_state)
  );

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_ready      <= 1'b1;
      ram_read_valid <= 1'b0;
      busy           <= 0;
      rv_pend        <= 1'b0;
    end else if (ram_en && ram_ready) begin
      busy      <= 2;
      ctl_ready <= 1'b0;
      if (ram_mem_op == 2'b01) begin
        ram_read_valid <= 1'b0;
        rv_pend        <= 1'b1;
      end
    end else if (busy > 0) begin
      busy <= busy - 1;
      if (busy == 1) ctl_ready <= 1'b1;
    end else if (rv_pend) begin
      ram_read_valid <= 1'b1;
      rv_pend        <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz,
                                           input logic u, input logic [31:0] d);
    logic [31:0] v;
    v = d >> (8 * (a % 4));
    if (sz == 2'd0) begin
      v = v % 256;
      if (!u && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = v % 65536;
      if (!u && v >= 32768) v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [3:0] ref_we(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'd0) return 4'(1 << (a % 4));
    if (sz == 2'd1) return (a % 4 >= 2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] ref_din(input logic [31:0] w, input logic [1:0] sz);
    if (sz == 2'd0) return (w % 256) * 32'h0101_0101;
    if (sz == 2'd1) return (w % 65536) * 32'h0001_0001;
    return w;
  endfunction

  // Drives one request, measures response latency from the accepting edge and ram_en cycles.
  task automatic run_req(input logic [1:0] op, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int stall, input bit stuck, input int hold,
                         output int lat, output int en_cnt, output logic [31:0] data,
                         output logic err, output logic [3:0] we_s,
                         output logic [31:0] din_s, output logic [16:0] addr_s);
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_op       = op;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    resp_ready   = (hold == 0);
    force_low    = (stall > 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat    = -1;
    en_cnt = 0;
    we_s   = 4'b0000;
    din_s  = 32'h0;
    addr_s = 17'h0;
    for (int k = 0; k < 60; k++) begin
      force_low = (k < stall) || (stuck && k > stall);
      #0;
      if (resp_valid) begin
        lat = k;
        break;
      end
      if (ram_en) begin
        en_cnt++;
        we_s   = ram_we;
        din_s  = ram_din;
        addr_s = ram_addr;
      end
      @(posedge clk);
      #1;
    end
    force_low = 1'b0;
    data = resp_data;
    err  = resp_err;
    if (lat >= 0) begin
      for (int h = 0; h < hold; h++) begin
        chk("hold_valid", 32'(resp_valid), 32'd1);
        chk("hold_data", resp_data, data);
        chk("hold_err", 32'(resp_err), 32'(err));
        chk("hold_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("resp_done", 32'(resp_valid), 32'd0);
    end
  endtask

  // Runs a request and compares everything against the reference rules.
  task automatic model_check(input string tag, input logic [1:0] op, input logic [1:0] size,
                             input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] dout, input int stall, input bit stuck,
                             input int hold, output int lat, output int en_cnt,
                             output logic [31:0] data, output logic err,
                             output logic [3:0] we_s, output logic [31:0] din_s);
    logic [16:0] addr_s;
    bit          bad;
    int          exp_lat, exp_en;
    logic [31:0] exp_data;
    logic        exp_err;
    ram_dout = dout;
    run_req(op, size, uns, addr, wdata, stall, stuck, hold, lat, en_cnt, data, err, we_s, din_s, addr_s);
    bad = !(op == 2'd1 || op == 2'd2) || size == 2'd3 ||
          (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0) ||
          (addr / 32'h0002_0000 != 32'h4000);
    if (bad) begin
      exp_lat = 0; exp_en = 0; exp_err = 1'b1; exp_data = 32'h0;
    end else if (stuck) begin
      exp_lat = 16 + stall; exp_en = 16 + stall; exp_err = 1'b1; exp_data = 32'h0;
    end else begin
      exp_lat  = ((op == 2'd1) ? 5 : 4) + stall;
      exp_en   = 3 + stall;
      exp_err  = 1'b0;
      exp_data = (op == 2'd1) ? ref_load(addr, size, uns, dout) : 32'h0;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_en_cycles"}, 32'(en_cnt), 32'(exp_en));
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_data"}, data, exp_data);
    if (!bad) begin
      chk({tag, "_ram_addr"}, 32'(addr_s), addr % 32'h0002_0000);
      chk({tag, "_ram_we"}, 32'(we_s), (op == 2'd1) ? 32'd0 : 32'(ref_we(addr, size)));
      if (op == 2'd2) chk({tag, "_ram_din"}, din_s, ref_din(wdata, size));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, en_cnt;
    logic [31:0] data, din_s, addr, wdata;
    logic        err;
    logic [3:0]  we_s;
    logic [1:0]  op, size;
    int          r;

    rst = 1'b1;
    req_valid = 1'b0; req_op = 2'b00; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;
    force_low = 1'b0; ram_dout = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_data", resp_data, 32'h0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_din", ram_din, 32'h0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_op_size", 32'({ram_mem_op, ram_mem_size}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);
    chk("post_rst_state", 32'(dbg_state), 32'd0);

    model_check("ld_word", 2'b01, 2'b10, 1'b0, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 0, 0, 0,
                lat, en_cnt, data, err, we_s, din_s);
    chk("ld_word_lit_data", data, 32'hDEAD_BEEF);
    chk("ld_word_lit_lat", 32'(lat), 32'd5);
    chk("ld_word_lit_en", 32'(en_cnt), 32'd3);

    model_check("ld_byte_s", 2'b01, 2'b00, 1'b0, 32'h8000_0003, 32'h0, 32'h80FF_FF7F, 0, 0, 0,
                lat, en_cnt, data, err, we_s, din_s);
    chk("ld_byte_s_lit", data, 32'hFFFF_FF80);

    model_check("ld_half_u", 2'b01, 2'b01, 1'b1, 32'h8000_0002, 32'h0, 32'h80FF_FF7F, 0, 0, 0,
                lat, en_cnt, data, err, we_s, din_s);
    chk("ld_half_u_lit", data, 32'h0000_80FF);

    model_check("st_half", 2'b10, 2'b01, 1'b0, 32'h8000_0006, 32'h1234_ABCD, 32'h0, 0, 0, 0,
                lat, en_cnt, data, err, we_s, din_s);
    chk("st_half_lit_we", 32'(we_s), 32'hC);
    chk("st_half_lit_din", din_s, 32'hABCD_ABCD);
    chk("st_half_lit_lat", 32'(lat), 32'd4);

    model_check("ld_misal", 2'b01, 2'b10, 1'b0, 32'h8000_0001, 32'h0, 32'h1111_2222, 0, 0, 0,
                lat, en_cnt, data, err, we_s, din_s);
    chk("ld_misal_lit_err", 32'(err), 32'd1);
    chk("ld_misal_lit_en", 32'(en_cnt), 32'd0);

    model_check("ld_window", 2'b01, 2'b10, 1'b0, 32'h9000_0000, 32'h0, 32'h1111_2222, 0, 0, 0,
                lat, en_cnt, data, err, we_s, din_s);
    chk("ld_window_lit_err", 32'(err), 32'd1);
    chk("ld_window_lit_en", 32'(en_cnt), 32'd0);

    model_check("ld_stall4", 2'b01, 2'b10, 1'b0, 32'h8000_0100, 32'h0, 32'h0BAD_F00D, 4, 0, 0,
                lat, en_cnt, data, err, we_s, din_s);
    chk("ld_stall4_lit_lat", 32'(lat), 32'd9);

    model_check("ld_timeout", 2'b01, 2'b10, 1'b0, 32'h8000_0200, 32'h0, 32'h5555_AAAA, 0, 1, 0,
                lat, en_cnt, data, err, we_s, din_s);
    chk("ld_timeout_lit_err", 32'(err), 32'd1);
    chk("ld_timeout_lit_lat", 32'(lat), 32'd16);

    // Reset pulse while the load is in WAIT must drop it without a response.
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b01; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h8000_0040; ram_dout = 32'hCAFE_0001;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_state_wait", 32'(dbg_state), 32'd2);
    rst = 1'b1;
    #1;
    chk("mid_rst_en", 32'(ram_en), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("mid_rst_no_resp", 32'(resp_valid), 32'd0);
    end
    model_check("ld_after_rst", 2'b01, 2'b10, 1'b0, 32'h8000_0044, 32'h0, 32'h0F0F_1234, 0, 0, 0,
                lat, en_cnt, data, err, we_s, din_s);

    model_check("ld_hold3", 2'b01, 2'b00, 1'b1, 32'h8000_0005, 32'h0, 32'h00C3_A500, 0, 0, 3,
                lat, en_cnt, data, err, we_s, din_s);
    chk("ld_hold3_lit", data, 32'h0000_00A5);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      op = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r < 6) ? 2'b01 : 2'b10;
      r = $urandom_range(0, 9);
      size = (r == 0) ? 2'b11 : 2'(r % 3);
      if ($urandom_range(0, 5) != 0) addr = {15'h4000, 17'($urandom)};
      else addr = $urandom;
      if ($urandom_range(0, 2) != 0) addr = addr - (addr % ((size == 2'b10) ? 4 : 2));
      wdata = $urandom;
      model_check($sformatf("rnd%0d", i), op, size, 1'($urandom_range(0, 1)), addr, wdata,
                  $urandom, $urandom_range(0, 2), 0, $urandom_range(0, 2),
                  lat, en_cnt, data, err, we_s, din_s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
